// File: rtl/dds_wave_oscillator_if.sv
`default_nettype none
// ============================================================================
//  Module   : dds_wave_oscillator_if
//  Purpose  : Control and sample-stream bundle for the DDS wave oscillator.
//             Groups the control inputs (frequency, waveform, duty), the
//             downstream ready, and the output sample/valid/overrun signals.
//  Modports : master - control front end / sample consumer side
//             slave  - oscillator side
//  Signals  : freq_ctrl_i  [15:0]       requested frequency in Hz (0 = hold)
//             wave_sel_i   [1:0]        0=sine 1=square 2=triangle 3=saw
//             duty_i       [7:0]        square high-time threshold
//             ready_i                   downstream accepts a sample
//             data_o       [width_p-1:0] signed sample
//             valid_o                   data_o holds an unconsumed sample
//             overrun_o                 one-cycle pulse on a dropped sample
//  Revision : 1.0 - initial release
// ============================================================================
interface dds_wave_oscillator_if #(
  parameter int width_p = 12
);
  logic        [15:0]        freq_ctrl_i;
  logic        [1:0]         wave_sel_i;
  logic        [7:0]         duty_i;
  logic                      ready_i;
  logic signed [width_p-1:0] data_o;
  logic                      valid_o;
  logic                      overrun_o;

  modport master (
    output freq_ctrl_i,
    output wave_sel_i,
    output duty_i,
    output ready_i,
    input  data_o,
    input  valid_o,
    input  overrun_o
  );

  modport slave (
    input  freq_ctrl_i,
    input  wave_sel_i,
    input  duty_i,
    input  ready_i,
    output data_o,
    output valid_o,
    output overrun_o
  );
endinterface
`default_nettype wire

// File: rtl/dds_wave_oscillator.sv
`default_nettype none
// ============================================================================
//  Module   : dds_wave_oscillator
//  Purpose  : Single-channel direct-digital-synthesis oscillator. A phase
//             accumulator advances once per audio sample tick; each tick
//             produces one sine / square / triangle / sawtooth sample that is
//             offered downstream through a one-entry ready/valid register.
//             Samples that cannot be accepted are dropped and flagged.
//  Ports    : clk_i    - clock
//             reset_i  - asynchronous active-high reset
//             bus      - dds_wave_oscillator_if.slave (controls + sample out)
//  Revision : 1.0 - initial release
// ============================================================================
module dds_wave_oscillator #(
  parameter int width_p          = 12,
  parameter int clk_freq_p       = 12_000_000,
  parameter int sample_rate_p    = 48_000,
  parameter int phase_width_p    = 24,
  parameter int lut_addr_width_p = 8
) (
  input  wire logic             clk_i,
  input  wire logic             reset_i,
  dds_wave_oscillator_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_div   = clk_freq_p / sample_rate_p;
  localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;

  // Phase increment per Hz, pre-scaled by 2**8 so the final >>8 keeps
  // fractional precision of the per-Hz step.
  localparam logic [63:0] c_scale =
    (64'd1 << (phase_width_p + 8)) / 64'(sample_rate_p);

  // Nyquist clamp for the requested frequency.
  localparam logic [16:0] c_f_max = 17'(sample_rate_p / 2);

  localparam int c_max   = 2 ** (width_p - 1) - 1;
  localparam int c_q_w   = lut_addr_width_p - 2;
  localparam int c_n     = 2 ** c_q_w;

  localparam logic signed [width_p-1:0] c_smax = width_p'(c_max);
  localparam logic signed [width_p-1:0] c_smin = {1'b1, {(width_p-1){1'b0}}};

  // Triangle arithmetic runs two bits wider so the fold never wraps.
  localparam logic signed [width_p+1:0] c_tri_half = (width_p+2)'(2 ** (width_p - 1));
  localparam logic signed [width_p+1:0] c_tri_max  = (width_p+2)'(c_max);
  localparam logic signed [width_p+1:0] c_tri_min  = -c_tri_half;

  // --------------------------------------------------------------------------
  // Quarter-wave ROM contents: entry k = round(MAX * sin(pi/2 * (k+0.5)/N)).
  // Evaluated at elaboration with a Q30 fixed-point Taylor series so no real
  // arithmetic reaches synthesis. Seven correction terms give an error far
  // below one output LSB over [0, pi/2].
  // --------------------------------------------------------------------------
  function automatic logic signed [width_p-1:0] sine_entry(input int k);
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint v;
    // 3373259426 = round(pi * 2**30)
    x    = (64'sd3373259426 * longint'(2 * k + 1)) / longint'(4 * c_n);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int i = 1; i <= 7; i++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * i) * (2 * i + 1)));
      acc  = acc + term;
    end
    v = (longint'(c_max) * acc + (64'sd1 <<< 29)) >>> 30;
    return width_p'(v);
  endfunction

  logic signed [width_p-1:0] w_rom [c_n];

  for (genvar k = 0; k < c_n; k++) begin : g_rom
    localparam logic signed [width_p-1:0] c_entry = sine_entry(k);
    assign w_rom[k] = c_entry;
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic        [c_cnt_w-1:0]       r_tick_cnt;
  logic        [phase_width_p-1:0] r_phase;
  logic        [15:0]              r_freq;
  logic        [1:0]               r_sel;
  logic        [7:0]               r_duty;
  logic signed [width_p-1:0]       r_data;
  logic                            r_valid;
  logic                            r_overrun;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic                            w_tick;
  logic                            w_transfer;
  logic        [15:0]              w_freq;
  logic        [1:0]               w_sel;
  logic        [7:0]               w_duty;
  logic        [15:0]              w_freq_clamped;
  logic        [phase_width_p-1:0] w_inc;

  logic        [lut_addr_width_p-1:0] w_lut_addr;
  logic        [1:0]                  w_quad;
  logic        [c_q_w-1:0]            w_rom_idx;
  logic signed [width_p-1:0]          w_rom_val;
  logic        [width_p-1:0]          w_top;
  logic        [7:0]                  w_duty_phase;

  logic signed [width_p-1:0] w_sine;
  logic signed [width_p-1:0] w_square;
  logic signed [width_p-1:0] w_saw;
  logic signed [width_p-1:0] w_tri;
  logic signed [width_p+1:0] w_tri_dist;
  logic signed [width_p+1:0] w_tri_abs;
  logic signed [width_p+1:0] w_tri_full;
  logic signed [width_p-1:0] w_sample;

  assign w_tick     = (r_tick_cnt == c_cnt_w'(c_div - 1));
  assign w_transfer = r_valid & bus.ready_i;

  // Controls are only consumed on a tick. On that cycle the live inputs are
  // used directly, so the sample produced on the tick already reflects a new
  // waveform/duty; between ticks the latched copies are presented instead.
  assign w_freq = w_tick ? bus.freq_ctrl_i : r_freq;
  assign w_sel  = w_tick ? bus.wave_sel_i  : r_sel;
  assign w_duty = w_tick ? bus.duty_i      : r_duty;

  assign w_freq_clamped = ({1'b0, w_freq} > c_f_max) ? c_f_max[15:0] : w_freq;

  // Full 64-bit product: 16-bit frequency times the scale cannot overflow.
  assign w_inc = phase_width_p'((64'(w_freq_clamped) * c_scale) >> 8);

  // Sine: the top two LUT-address bits pick the quadrant. Odd quadrants read
  // the ROM backwards (N-1-k == ~k), the second half-wave negates.
  assign w_lut_addr = r_phase[phase_width_p-1 -: lut_addr_width_p];
  assign w_quad     = w_lut_addr[lut_addr_width_p-1 -: 2];
  assign w_rom_idx  = w_quad[0] ? ~w_lut_addr[c_q_w-1:0] : w_lut_addr[c_q_w-1:0];
  assign w_rom_val  = w_rom[w_rom_idx];
  assign w_sine     = w_quad[1] ? -w_rom_val : w_rom_val;

  // Square: high while the top phase byte is below the duty threshold.
  assign w_duty_phase = r_phase[phase_width_p-1 -: 8];
  assign w_square     = (w_duty_phase < w_duty) ? c_smax : c_smin;

  // Sawtooth: top phase bits offset by half scale, i.e. MSB inverted.
  assign w_top = r_phase[phase_width_p-1 -: width_p];
  assign w_saw = {~w_top[width_p-1], w_top[width_p-2:0]};

  // Triangle: MAX - 2*|top - half|. This peaks at half phase and reaches
  // MIN-1 at phase 0, which the saturation pulls back to MIN.
  always_comb begin
    w_tri_dist = $signed({2'b00, w_top}) - c_tri_half;
    w_tri_abs  = w_tri_dist[width_p+1] ? -w_tri_dist : w_tri_dist;
    w_tri_full = c_tri_max - (w_tri_abs <<< 1);
    w_tri      = (w_tri_full < c_tri_min) ? c_smin : w_tri_full[width_p-1:0];
  end

  always_comb begin
    w_sample = w_saw;
    case (w_sel)
      2'd0:    w_sample = w_sine;
      2'd1:    w_sample = w_square;
      2'd2:    w_sample = w_tri;
      default: w_sample = w_saw;
    endcase
  end

  // --------------------------------------------------------------------------
  // Tick divider, phase accumulator and control latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_tick_cnt <= '0;
      r_phase    <= '0;
      r_freq     <= '0;
      r_sel      <= '0;
      r_duty     <= '0;
    end else begin
      if (w_tick) begin
        r_tick_cnt <= '0;
        // Sample above was taken from the pre-update phase; wrap is silent.
        r_phase    <= r_phase + w_inc;
        r_freq     <= bus.freq_ctrl_i;
        r_sel      <= bus.wave_sel_i;
        r_duty     <= bus.duty_i;
      end else begin
        r_tick_cnt <= r_tick_cnt + c_cnt_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // One-entry output register. A tick loads a new sample whenever the slot
  // is empty or is being drained this cycle (no bubble on back-to-back);
  // otherwise the held sample stays stable and the new one is dropped.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_tick) begin
        if (!r_valid || bus.ready_i) begin
          r_data  <= w_sample;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_transfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data_o    = r_data;
  assign bus.valid_o   = r_valid;
  assign bus.overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_dds_wave_oscillator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_wave_oscillator
//  Purpose  : Self-checking bench for dds_wave_oscillator. A behavioural
//             reference (plain arithmetic on phase, $sin for the sine wave)
//             predicts valid/data/overrun every cycle; scenario tasks add
//             fixed expectations for the documented operating points.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_wave_oscillator;

  localparam int W     = 12;
  localparam int CLK_F = 12_000_000;
  localparam int SR    = 48_000;
  localparam int PW    = 24;
  localparam int LA    = 8;
  localparam int DIV   = CLK_F / SR;
  localparam int SMAX  = 2 ** (W - 1) - 1;
  localparam int SMIN  = -(2 ** (W - 1));
  localparam longint PMOD = longint'(1) << PW;
  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  // reference state
  int     m_cnt;
  longint m_phase;
  bit     m_valid;
  bit     m_ov;
  int     m_data;
  bit     m_tol;

  dds_wave_oscillator_if #(.width_p(W)) bus ();

  dds_wave_oscillator #(
    .width_p          (W),
    .clk_freq_p       (CLK_F),
    .sample_rate_p    (SR),
    .phase_width_p    (PW),
    .lut_addr_width_p (LA)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  function automatic longint ref_inc(int f);
    longint fc;
    longint scale;
    fc    = (f > SR / 2) ? SR / 2 : f;
    scale = (longint'(1) << (PW + 8)) / SR;
    return ((fc * scale) >> 8) % PMOD;
  endfunction

  function automatic int ref_sample(longint ph, int sel, int duty, output bit tol);
    int  t;
    int  v;
    real r;
    tol = 1'b0;
    t   = int'(ph >> (PW - W));
    case (sel)
      0: begin
        r   = SMAX * $sin(2.0 * PI * (real'(ph >> (PW - LA)) + 0.5) / real'(2 ** LA));
        v   = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        tol = 1'b1;
      end
      1: v = (int'(ph >> (PW - 8)) < duty) ? SMAX : SMIN;
      2: begin
        v = SMAX - 2 * ((t >= 2 ** (W - 1)) ? t - 2 ** (W - 1) : 2 ** (W - 1) - t);
        if (v < SMIN) v = SMIN;
      end
      default: v = t - 2 ** (W - 1);
    endcase
    return v;
  endfunction

  // Advance one clock: update the reference from the inputs seen at the edge,
  // then return at the following falling edge for sampling/driving.
  task automatic clk_step();
    bit tick;
    bit t;
    int s;
    @(posedge clk);
    tick = (m_cnt == DIV - 1);
    s    = ref_sample(m_phase, int'(bus.wave_sel_i), int'(bus.duty_i), t);
    if (tick) begin
      if (!m_valid || bus.ready_i) begin
        m_data  = s;
        m_tol   = t;
        m_valid = 1'b1;
        m_ov    = 1'b0;
      end else begin
        m_ov = 1'b1;
      end
      m_phase = (m_phase + ref_inc(int'(bus.freq_ctrl_i))) % PMOD;
      m_cnt   = 0;
    end else begin
      m_ov = 1'b0;
      if (m_valid && bus.ready_i) m_valid = 1'b0;
      m_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    m_cnt   = 0;
    m_phase = 0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_data  = 0;
    m_tol   = 1'b0;
  endtask

  task automatic set_ctrl(int f, int sel, int duty, bit rdy);
    bus.freq_ctrl_i = 16'(f);
    bus.wave_sel_i  = 2'(sel);
    bus.duty_i      = 8'(duty);
    bus.ready_i     = rdy;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    set_ctrl(440, 3, 0, 1'b1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.overrun_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got v=%b d=%0d o=%b, want v=0 d=0 o=0",
               bus.valid_o, bus.data_o, bus.overrun_o);
    end
    do_reset();
    repeat (DIV - 1) clk_step();
    n_checks++;
    if (bus.valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL first_tick_early: got valid=%b after %0d clk, want 0", bus.valid_o, DIV - 1);
    end
    clk_step();
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== -12'sd2048) begin
      n_errors++;
      $display("FAIL first_sample: got v=%b d=%0d, want v=1 d=-2048", bus.valid_o, bus.data_o);
    end
  endtask

  task automatic test_saw_stream();
    int q[$];
    int de;
    set_ctrl(440, 3, 0, 1'b1);
    do_reset();
    repeat (5 * DIV + 2) begin
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > (m_tol ? 1 : 0)) begin
        n_errors++;
        $display("FAIL saw_stream: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data);
      end
      if (bus.valid_o === 1'b1) q.push_back(int'(bus.data_o));
    end
    n_checks++;
    if (q.size() != 5 || q[0] != -2048 || q[1] != -2011) begin
      n_errors++;
      $display("FAIL saw_440_start: got n=%0d s0=%0d s1=%0d, want n=5 s0=-2048 s1=-2011",
               q.size(), q[0], q[1]);
    end
    for (int i = 1; i < q.size(); i++) begin
      n_checks++;
      if (q[i] - q[i-1] != 37 && q[i] - q[i-1] != 38) begin
        n_errors++;
        $display("FAIL saw_440_step: got step %0d at %0d, want 37 or 38", q[i] - q[i-1], i);
      end
    end
  endtask

  task automatic test_backpressure();
    int ovs;
    int de;
    set_ctrl(440, 3, 0, 1'b0);
    do_reset();
    repeat (DIV) clk_step();
    ovs = 0;
    repeat (600) begin
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > 0) begin
        n_errors++;
        $display("FAIL backpressure: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data);
      end
      if (bus.overrun_o === 1'b1) ovs++;
    end
    n_checks++;
    if (ovs != 2 || bus.data_o !== -12'sd2048 || bus.valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL backpressure_hold: got overruns=%0d d=%0d v=%b, want 2 -2048 1",
               ovs, bus.data_o, bus.valid_o);
    end
    bus.ready_i = 1'b1;
    repeat (DIV + 10) begin
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > 0) begin
        n_errors++;
        $display("FAIL backpressure_release: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data);
      end
    end
  endtask

  task automatic test_ctrl_change();
    int q[$];
    int de;
    set_ctrl(440, 3, 0, 1'b1);
    do_reset();
    for (int c = 0; c < 6 * DIV + 100; c++) begin
      if (c == 3 * DIV + 100) bus.freq_ctrl_i = 16'd880;
      if (c == 5 * DIV + 100) bus.wave_sel_i  = 2'd2;
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > 0) begin
        n_errors++;
        $display("FAIL ctrl_change: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data);
      end
      if (bus.valid_o === 1'b1 && c < 5 * DIV + 100) q.push_back(int'(bus.data_o));
    end
    // q[3] is taken on the first tick after the change: pre-update phase, old step.
    n_checks++;
    if (q.size() != 5 || !((q[3] - q[2]) inside {37, 38}) || !((q[4] - q[3]) inside {75, 76})) begin
      n_errors++;
      $display("FAIL freq_880_step: got n=%0d steps %0d %0d, want n=5 steps 37/38 then 75/76",
               q.size(), q[3] - q[2], q[4] - q[3]);
    end
  endtask

  task automatic test_clamp_hold();
    int q[$];
    set_ctrl(30000, 3, 0, 1'b1);
    do_reset();
    for (int c = 0; c < 6 * DIV + 2; c++) begin
      if (c == 3 * DIV + 50) bus.freq_ctrl_i = 16'd0;
      clk_step();
      if (bus.valid_o === 1'b1) q.push_back(int'(bus.data_o));
    end
    // clamped inc 8388562: phase 8388562 and later 8388470 both map to -1
    n_checks++;
    if (q.size() != 6 || q[0] != -2048 || q[1] != -1 || q[2] != 2047) begin
      n_errors++;
      $display("FAIL clamp_24k: got n=%0d %0d %0d %0d, want n=6 -2048 -1 2047",
               q.size(), q[0], q[1], q[2]);
    end
    n_checks++;
    if (q[3] != -1 || q[4] != -1 || q[5] != -1) begin
      n_errors++;
      $display("FAIL freq_zero_hold: got %0d %0d %0d, want -1 -1 -1", q[3], q[4], q[5]);
    end
  endtask

  task automatic test_sine_square();
    int de;
    int nmax;
    int nsamp;
    set_ctrl(12000, 0, 0, 1'b1);
    do_reset();
    repeat (8 * DIV + 2) begin
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > (m_tol ? 1 : 0)) begin
        n_errors++;
        $display("FAIL sine_12k: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data);
      end
    end
    set_ctrl(375, 1, 64, 1'b1);
    do_reset();
    nmax  = 0;
    nsamp = 0;
    repeat (128 * DIV + 1) begin
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > 0) begin
        n_errors++;
        $display("FAIL square_375: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data);
      end
      if (bus.valid_o === 1'b1) begin
        nsamp++;
        if (bus.data_o === 12'sd2047) nmax++;
      end
    end
    n_checks++;
    if (nsamp != 128 || nmax < 32 || nmax > 33) begin
      n_errors++;
      $display("FAIL square_duty64: got %0d high of %0d samples, want 32..33 of 128", nmax, nsamp);
    end
  endtask

  task automatic test_random();
    int de;
    set_ctrl(1000, 3, 128, 1'b1);
    do_reset();
    for (int c = 0; c < 25 * DIV; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        bus.freq_ctrl_i = 16'($urandom_range(0, 30000));
        bus.wave_sel_i  = 2'($urandom_range(0, 3));
        bus.duty_i      = 8'($urandom_range(0, 255));
      end
      bus.ready_i = ($urandom_range(0, 3) != 0);
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > (m_tol ? 1 : 0)) begin
        n_errors++;
        $display("FAIL random: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d (f=%0d sel=%0d duty=%0d)",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data,
                 bus.freq_ctrl_i, bus.wave_sel_i, bus.duty_i);
      end
    end
  endtask

  task automatic test_reset_async();
    int de;
    set_ctrl(440, 3, 0, 1'b0);
    do_reset();
    repeat (2 * DIV + 20) clk_step();
    n_checks++;
    if (bus.valid_o !== 1'b1) begin
      n_errors++;
      $display("FAIL async_reset_pre: got valid=%b, want 1", bus.valid_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.valid_o !== 1'b0 || bus.data_o !== '0 || bus.overrun_o !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: got v=%b d=%0d o=%b before edge, want 0 0 0",
               bus.valid_o, bus.data_o, bus.overrun_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    bus.ready_i = 1'b1;
    m_cnt       = 0;
    m_phase     = 0;
    m_valid     = 1'b0;
    m_ov        = 1'b0;
    m_data      = 0;
    m_tol       = 1'b0;
    repeat (DIV + 5) begin
      clk_step();
      de = int'(bus.data_o) - m_data;
      if (de < 0) de = -de;
      n_checks++;
      if (bus.valid_o !== m_valid || bus.overrun_o !== m_ov || $isunknown(bus.data_o) || de > 0) begin
        n_errors++;
        $display("FAIL async_restart: got v=%b o=%b d=%0d, want v=%b o=%b d=%0d",
                 bus.valid_o, bus.overrun_o, bus.data_o, m_valid, m_ov, m_data);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    set_ctrl(0, 0, 0, 1'b0);
    test_reset();
    test_saw_stream();
    test_backpressure();
    test_ctrl_change();
    test_clamp_hold();
    test_sine_square();
    test_random();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
